// File: rtl/vpe_solve_ctrl_if.sv
// vpe_solve_ctrl_if: clause-SRAM write handshake between loader and controller
interface vpe_solve_ctrl_if;
  logic valid;
  logic last;
  logic ready;
  logic stb;
  modport master (output valid, last, input ready, stb);
  modport slave (input valid, last, output ready, stb);
endinterface

// File: rtl/vpe_solve_ctrl.sv
// vpe_solve_ctrl: mode/strobe sequencer for a VPE clause/variable array
module vpe_solve_ctrl #(
  parameter int NVAR = 60,
  parameter int EVAL_CYC = 3,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  vpe_solve_ctrl_if.slave   wr,
  input  logic              load_start,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        cfg_nvar,
  input  logic [ITER_W-1:0] cfg_max_iter,
  input  logic [ITER_W-1:0] cfg_stoch_iter,
  input  logic              cfg_merge,
  input  logic              cfg_vpre,
  input  logic              satisfy,
  output logic              sram_state,
  output logic              var_state,
  output logic              v_pre,
  output logic [NVAR-1:0]   vul_en,
  output logic              stochastic_mode,
  output logic              merge,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic [ITER_W-1:0] iter_cnt
);
  localparam int IW = $clog2(NVAR + 1);
  localparam int EW = $clog2(EVAL_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WRSTB, INIT, EVAL, UPD, CHECK, FIN} state_t;
  state_t state, nxt;
  logic [IW-1:0] nvar, nvar_n, idx, idx_n;
  logic [EW-1:0] ec, ec_n;
  logic [ITER_W-1:0] max_iter, max_n, stoch, stoch_n, iter_n;
  logic merge_sh, merge_sh_n, last_q, last_n, solved_n, go;
  logic ready_n, stb_n, sram_n, var_n, vpre_n, smode_n, merge_n, busy_n, done_n;
  logic [NVAR-1:0] vul_n;
  // Next-state, shadow-register and registered-output computation
  always_comb begin
    nxt = state;
    nvar_n = nvar;
    max_n = max_iter;
    stoch_n = stoch;
    merge_sh_n = merge_sh;
    idx_n = idx;
    iter_n = iter_cnt;
    solved_n = solved;
    last_n = last_q;
    go = 1'b0;
    case (state)
      IDLE:  begin
        nxt = load_start ? LOAD : IDLE;
        go = start && !load_start;
      end
      LOAD:  begin
        nxt = wr.valid ? WRSTB : LOAD;
        last_n = wr.valid ? wr.last : last_q;
      end
      WRSTB: nxt = last_q ? IDLE : LOAD;
      INIT:  nxt = (nvar == '0) ? CHECK : EVAL;
      EVAL:  nxt = (int'(ec) == EVAL_CYC - 1) ? UPD : EVAL;
      UPD:   begin
        nxt = (int'(idx) == int'(nvar) - 1) ? CHECK : EVAL;
        idx_n = (nxt == CHECK) ? '0 : idx + 1'b1;
      end
      CHECK: begin
        iter_n = (&iter_cnt) ? iter_cnt : iter_cnt + 1'b1;
        solved_n = satisfy;
        nxt = (satisfy || ({1'b0, iter_cnt} + 1'b1 >= {1'b0, max_iter})) ? FIN : EVAL;
      end
      FIN:   begin
        nxt = IDLE;
        go = start;
      end
      default: nxt = IDLE;
    endcase
    if (go) begin
      nxt = INIT;
      nvar_n = (int'(cfg_nvar) > NVAR) ? IW'(NVAR) : IW'(cfg_nvar);
      max_n = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
      stoch_n = cfg_stoch_iter;
      merge_sh_n = cfg_merge;
      idx_n = '0;
      iter_n = '0;
      solved_n = 1'b0;
    end
    if (abort) begin
      solved_n = 1'b0;
      nxt = (state == IDLE) ? nxt : IDLE;
    end
    ec_n = (state == EVAL && nxt == EVAL) ? ec + 1'b1 : '0;
    ready_n = nxt == LOAD;
    stb_n = nxt == WRSTB;
    sram_n = nxt == LOAD || nxt == WRSTB;
    var_n = nxt == INIT;
    vpre_n = nxt == INIT && cfg_vpre;
    smode_n = (nxt == EVAL || nxt == UPD || nxt == CHECK) && iter_n < stoch_n;
    merge_n = (nxt == INIT || nxt == EVAL || nxt == UPD || nxt == CHECK) && merge_sh_n;
    busy_n = nxt != IDLE && nxt != FIN;
    done_n = nxt == FIN;
    vul_n = '0;
    for (int k = 0; k < NVAR; k++)
      vul_n[k] = (nxt == INIT && k < int'(nvar_n)) || (nxt == UPD && k == int'(idx_n));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      nvar <= '0;
      idx <= '0;
      ec <= '0;
      max_iter <= '0;
      stoch <= '0;
      merge_sh <= 1'b0;
      last_q <= 1'b0;
      wr.ready <= 1'b0;
      wr.stb <= 1'b0;
      sram_state <= 1'b0;
      var_state <= 1'b0;
      v_pre <= 1'b0;
      vul_en <= '0;
      stochastic_mode <= 1'b0;
      merge <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      solved <= 1'b0;
      iter_cnt <= '0;
    end else begin
      state <= nxt;
      nvar <= nvar_n;
      idx <= idx_n;
      ec <= ec_n;
      max_iter <= max_n;
      stoch <= stoch_n;
      merge_sh <= merge_sh_n;
      last_q <= last_n;
      wr.ready <= ready_n;
      wr.stb <= stb_n;
      sram_state <= sram_n;
      var_state <= var_n;
      v_pre <= vpre_n;
      vul_en <= vul_n;
      stochastic_mode <= smode_n;
      merge <= merge_n;
      busy <= busy_n;
      done <= done_n;
      solved <= solved_n;
      iter_cnt <= iter_n;
    end
  end
endmodule

// File: tb/tb_vpe_solve_ctrl.sv
// tb_vpe_solve_ctrl: directed self-checking bench for vpe_solve_ctrl
module tb_vpe_solve_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0, start = 1'b0, abort = 1'b0;
  logic [5:0] cfg_nvar = 6'd4;
  logic [15:0] cfg_max_iter = 16'd5, cfg_stoch_iter = 16'd0;
  logic cfg_merge = 1'b0, cfg_vpre = 1'b0, satisfy = 1'b0;
  logic sram_state, var_state, v_pre, stochastic_mode, merge, busy, done, solved;
  logic [59:0] vul_en;
  logic [15:0] iter_cnt;
  int vectors = 0, miscompares = 0;
  vpe_solve_ctrl_if wr ();
  vpe_solve_ctrl #(.NVAR(60), .EVAL_CYC(3), .ITER_W(16)) dut (
    .clk(clk), .rst(rst), .wr(wr), .load_start(load_start), .start(start), .abort(abort),
    .cfg_nvar(cfg_nvar), .cfg_max_iter(cfg_max_iter), .cfg_stoch_iter(cfg_stoch_iter),
    .cfg_merge(cfg_merge), .cfg_vpre(cfg_vpre), .satisfy(satisfy),
    .sram_state(sram_state), .var_state(var_state), .v_pre(v_pre), .vul_en(vul_en),
    .stochastic_mode(stochastic_mode), .merge(merge), .busy(busy), .done(done),
    .solved(solved), .iter_cnt(iter_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int ups, cyc;
    bit seen;
    wr.valid = 1'b0;
    wr.last = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_vul", vul_en, 0);
    chk("rst_sram", sram_state, 0);
    chk("rst_ready", wr.ready, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_done", done, 0);
    tick;
    rst = 1'b0;
    wr.valid = 1'b1;
    tick;
    chk("idle_valid_ignored", sram_state, 0);
    chk("idle_stb", wr.stb, 0);
    // three back-to-back beats, third flagged last
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("load_sram_%0d", i), sram_state, i < 6);
      chk($sformatf("load_stb_%0d", i), wr.stb, (i % 2 == 1) && i < 6);
      chk($sformatf("load_ready_%0d", i), wr.ready, (i % 2 == 0) && i < 6);
      wr.last = (i == 4);
      if (i == 5) wr.valid = 1'b0;
      tick;
    end
    chk("load_idle_busy", busy, 0);
    // first pass solves: 4 variables, satisfy tied high
    cfg_nvar = 6'd4; cfg_max_iter = 16'd5; cfg_stoch_iter = 16'd0;
    cfg_merge = 1'b1; cfg_vpre = 1'b1; satisfy = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("init_var_state", var_state, 1);
    chk("init_vpre", v_pre, 1);
    chk("init_vul", vul_en, 64'hF);
    chk("init_busy", busy, 1);
    chk("init_merge", merge, 1);
    for (int c = 1; c <= 18; c++) begin
      tick;
      chk($sformatf("pass_vul_%0d", c), vul_en,
          (c % 4 == 0 && c <= 16) ? (64'd1 << (c / 4 - 1)) : 64'd0);
      chk($sformatf("pass_done_%0d", c), done, c == 18);
    end
    chk("pass_solved", solved, 1);
    chk("pass_iter", iter_cnt, 1);
    chk("pass_stoch", stochastic_mode, 0);
    tick;
    chk("pass_idle_busy", busy, 0);
    chk("pass_solved_held", solved, 1);
    chk("pass_done_drop", done, 0);
    chk("pass_merge_drop", merge, 0);
    // iteration limit with two stochastic iterations
    satisfy = 1'b0; cfg_max_iter = 16'd3; cfg_stoch_iter = 16'd2; cfg_merge = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_max_iter = 16'd50;
    chk("lim_start_clears_solved", solved, 0);
    for (int c = 0; c <= 52; c++) begin
      if (c > 0) tick;
      chk($sformatf("lim_stoch_%0d", c), stochastic_mode, c >= 1 && c <= 34);
      chk($sformatf("lim_done_%0d", c), done, c == 52);
    end
    chk("lim_solved", solved, 0);
    chk("lim_iter", iter_cnt, 3);
    tick;
    // clamp: 63 requested, 60 available
    cfg_nvar = 6'd63; cfg_max_iter = 16'd1; cfg_stoch_iter = 16'd0; satisfy = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("clamp_init_vul", vul_en, 64'h0FFF_FFFF_FFFF_FFFF);
    ups = 0; cyc = 0; seen = 0;
    for (int c = 1; c < 400 && !seen; c++) begin
      tick;
      if ($onehot(vul_en) && !var_state) ups++;
      if (done) begin
        seen = 1;
        cyc = c;
      end
    end
    chk("clamp_done_seen", 64'(seen), 1);
    chk("clamp_ups", 64'(ups), 60);
    chk("clamp_done_cyc", 64'(cyc), 242);
    tick;
    // zero variables, zero iteration limit behaves as one
    cfg_nvar = 6'd0; cfg_max_iter = 16'd0; satisfy = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_init", var_state, 1);
    chk("zero_init_vul", vul_en, 0);
    tick;
    chk("zero_check_busy", busy, 1);
    chk("zero_check_done", done, 0);
    tick;
    chk("zero_fin_done", done, 1);
    chk("zero_iter", iter_cnt, 1);
    chk("zero_solved", solved, 0);
    tick;
    // abort during the second update strobe
    cfg_nvar = 6'd4; cfg_max_iter = 16'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    chk("abort_upd2", vul_en, 64'h2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_vul", vul_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_solved", solved, 0);
    repeat (2) begin
      tick;
      chk("abort_no_done", done, 0);
    end
    // asynchronous reset mid-EVAL, then a clean rerun
    cfg_stoch_iter = 16'd5; cfg_merge = 1'b1; satisfy = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    chk("pre_rst_stoch", stochastic_mode, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stoch", stochastic_mode, 0);
    chk("arst_merge", merge, 0);
    tick;
    rst = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rerun_init_vul", vul_en, 64'hF);
    seen = 0; cyc = 0;
    for (int c = 1; c < 100 && !seen; c++) begin
      tick;
      if (done) begin
        seen = 1;
        cyc = c;
      end
    end
    chk("rerun_done_cyc", 64'(cyc), 18);
    chk("rerun_solved", solved, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
